uart_tx: RTL and testbench
==========================

# uart_tx

Parametrised UART transmitter, the next generation of the team's Tx block. It runs on a single system clock and derives bit timing internally from a clock divider, so no separate baud clock is needed. Data width, stop-bit count and parity sense are configurable, and the bus side uses a valid/ready handshake. It sits between a byte/word producer (FIFO or command engine) and the serial pin.

## Interface
- `CLK_DIV`, default 1250: clk cycles per bit period. Legal range is ≥ 2; out of range is an elaboration error.
- `DATA_BITS`, default 8: data bits per frame, 5..9.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Only meaningful with `UART_TX_PARITY_EN`.
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  request to send `i_data`.
- `i_data`  in  DATA_BITS  word to send, LSB first.
- `o_ready`  out  1  high only in IDLE; a transfer happens when `i_valid && o_ready`.
- `o_tx`  out  1  serial line, registered. Idle/mark is 1.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse in the last clk cycle of the final stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on handshake. `i_data` is latched into a shift register and baud counter and bit index are cleared.
- START -> DATA after one bit period.
- DATA: shifts out LSB first, one bit per bit period. After bit DATA_BITS-1, goes to PARITY if compiled in, else to STOP.
- PARITY -> STOP after one bit period.
- STOP: holds `o_tx`=1 for STOP_BITS bit periods, pulses `o_done` in the final cycle, then returns to IDLE.
- Baud counter is $clog2(CLK_DIV) bits and counts 0..CLK_DIV-1, wrapping to 0. Each bit lasts exactly CLK_DIV cycles.
- Bit index is $clog2(DATA_BITS) bits. Stop counter is 1 bit.
- Parity bit is the XOR of the latched data, inverted when PARITY_ODD=1.
- `i_data` changes after acceptance have no effect on the frame.
- `i_valid` while busy is ignored; nothing is queued.
- Reset values: state IDLE, `o_tx`=1, `o_busy`=0, `o_done`=0, counters 0, shift register 0. `o_ready`=1 from the first cycle after reset.
- Reset has priority over the handshake. `i_valid` in a reset cycle is not accepted.
- Reset mid-frame aborts the frame: `o_tx`=1 and `o_busy`=0 on the next edge, and no `o_done` is produced.

## Timing
- Handshake at cycle 0. `o_tx` drops to 0 at cycle 1.
- Start bit occupies cycles 1..CLK_DIV. Bit k occupies one CLK_DIV window after that.
- Frame length N = (1 + DATA_BITS + P + STOP_BITS) * CLK_DIV, where P = 1 with parity, else 0.
- `o_done` is high in cycle N.
- IDLE and `o_ready`=1 in cycle N+1. With `i_valid` held, the next handshake is at N+1 and the next start bit at N+2. This gives one guaranteed mark cycle between frames.
- `o_busy` is high in cycles 1..N.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity generator are present, parity bit follows PARITY_ODD, P=1.
- `UART_TX_PARITY_EN` not defined: PARITY state and parity logic are absent, DATA goes directly to STOP, PARITY_ODD is ignored, P=0.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding localparams UART_IDLE, UART_START, UART_DATA, UART_PARITY, UART_STOP;
  - legal-range constants for DATA_BITS and STOP_BITS, shared with the future receiver.
- Sub-module `uart_baud_gen`: CLK_DIV counter with sync clear and a one-cycle `bit_end` strobe. It is reused by the receiver.

## Test plan
- CLK_DIV=4, 8N1, send 0xA5:
  - `o_tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles;
  - `o_done` at cycle 40;
  - `o_ready` at cycle 41.
- Parity enabled, 8E1, send 0x07: parity bit 1, `o_done` at cycle 44. With PARITY_ODD=1, same data gives parity bit 0.
- `i_valid` held, 0x00 then 0xFF, CLK_DIV=4, 8N1:
  - second handshake at cycle 41;
  - second start bit spans cycles 42..45;
  - exactly one mark cycle (cycle 41) between frames.
- DATA_BITS=5, STOP_BITS=2, CLK_DIV=3, send 0x1F:
  - start bit cycles 1..3;
  - data 1s cycles 4..18;
  - stop cycles 19..24;
  - `o_done` at cycle 24.
- Reset asserted at cycle 15 of a frame: `o_tx`=1 and `o_busy`=0 at cycle 16, no `o_done`. After release, 0x3C is sent correctly.
- `i_data` toggled and `i_valid` pulsed mid-frame: waveform is identical to the unperturbed frame, and no second frame starts.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg : shared UART state encoding and parameter limits (Tx and Rx)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int UART_STATE_W = 3;

  localparam logic [UART_STATE_W-1:0] UART_IDLE   = 3'd0;
  localparam logic [UART_STATE_W-1:0] UART_START  = 3'd1;
  localparam logic [UART_STATE_W-1:0] UART_DATA   = 3'd2;
  localparam logic [UART_STATE_W-1:0] UART_PARITY = 3'd3;
  localparam logic [UART_STATE_W-1:0] UART_STOP   = 3'd4;

  localparam int UART_DATA_BITS_MIN = 5;
  localparam int UART_DATA_BITS_MAX = 9;
  localparam int UART_STOP_BITS_MIN = 1;
  localparam int UART_STOP_BITS_MAX = 2;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ----------------------------------------------------------------------------
// uart_baud_gen : CLK_DIV cycle bit-period counter with sync clear and bit_end
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_baud_gen #(
  parameter int CLK_DIV = 1250
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    bit_end_o = (cnt_q == CNT_LAST);
    if (clear_i || bit_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx : valid/ready UART transmitter; parity stage built when UART_TX_PARITY_EN
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 1250,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < UART_DATA_BITS_MIN || DATA_BITS > UART_DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS out of range");
  end
  if (STOP_BITS < UART_STOP_BITS_MIN || STOP_BITS > UART_STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS out of range");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  logic [UART_STATE_W-1:0] state_q, state_d;
  logic                    tx_q, tx_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    stop_q, stop_d;
  logic                    handshake;
  logic                    bit_end;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  assign handshake = (state_q == UART_IDLE) && i_valid;

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (handshake),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= UART_IDLE;
      tx_q     <= 1'b1;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // tx_d always carries the level of the coming cycle so o_tx stays registered
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (i_valid) begin
          state_d  = UART_START;
          tx_d     = 1'b0;
          shift_d  = i_data;
          idx_d    = '0;
          stop_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^i_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      UART_START: begin
        if (bit_end) begin
          state_d = UART_DATA;
          tx_d    = shift_q[0];
        end
      end
      UART_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = UART_PARITY;
            tx_d    = parity_q;
`else
            state_d = UART_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_PARITY: begin
        if (bit_end) begin
          state_d = UART_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      UART_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = UART_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = UART_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    o_ready = (state_q == UART_IDLE);
    o_busy  = (state_q != UART_IDLE);
    o_done  = (state_q == UART_STOP) && bit_end && (stop_q == STOP_LAST);
  end

  assign o_tx = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx : scoreboard bench for uart_tx (8-bit/div4, 5-bit/2-stop/div3, odd)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       va, vb, vc;
  logic [7:0] da, dc;
  logic [4:0] db;
  logic       ra, ta, ba, na;
  logic       rb, tb, bb, nb;
  logic       rc, tc, bc, nc;

  uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset(reset), .i_valid(va), .i_data(da),
    .o_ready(ra), .o_tx(ta), .o_busy(ba), .o_done(na));

  uart_tx #(.CLK_DIV(3), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset(reset), .i_valid(vb), .i_data(db),
    .o_ready(rb), .o_tx(tb), .o_busy(bb), .o_done(nb));

  uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut_c (
    .clk(clk), .reset(reset), .i_valid(vc), .i_data(dc),
    .o_ready(rc), .o_tx(tc), .o_busy(bc), .o_done(nc));

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } exp_t;

  exp_t expq[$];
  int   sel;
  int   n_checks;
  int   n_pass;
  int   cyc_in_frame;

  logic cur_tx, cur_busy, cur_done, cur_ready;
  always_comb begin
    case (sel)
      1:       begin cur_tx = tb; cur_busy = bb; cur_done = nb; cur_ready = rb; end
      2:       begin cur_tx = tc; cur_busy = bc; cur_done = nc; cur_ready = rc; end
      default: begin cur_tx = ta; cur_busy = ba; cur_done = na; cur_ready = ra; end
    endcase
  end

  function automatic int cdiv(int s);  return (s == 1) ? 3 : 4; endfunction
  function automatic int dbits(int s); return (s == 1) ? 5 : 8; endfunction
  function automatic int sbits(int s); return (s == 1) ? 2 : 1; endfunction
  function automatic int oddp(int s);  return (s == 2) ? 1 : 0; endfunction
  function automatic int frame_len(int s);
    return (1 + dbits(s) + P + sbits(s)) * cdiv(s);
  endfunction

  // Reference serial level in frame cycle c (1..N)
  function automatic logic model_tx(int s, int d, int c);
    logic [8:0] dv;
    logic       par;
    int         slot;
    dv   = 9'(d);
    slot = (c - 1) / cdiv(s);
    par  = (oddp(s) != 0);
    for (int i = 0; i < dbits(s); i++) par = par ^ dv[i];
    if (slot == 0) return 1'b0;
    if (slot <= dbits(s)) return dv[slot-1];
    if (P == 1 && slot == dbits(s) + 1) return par;
    return 1'b1;
  endfunction

  task automatic push_frame(int s, int d);
    exp_t e;
    for (int c = 1; c <= frame_len(s); c++) begin
      e.tx   = model_tx(s, d, c);
      e.busy = 1'b1;
      e.done = (c == frame_len(s));
      expq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      cyc_in_frame++;
      n_checks++;
      if (cur_tx !== e.tx || cur_busy !== e.busy || cur_done !== e.done) begin
        $display("FAIL frame sel=%0d cyc=%0d: tx/busy/done got %b%b%b want %b%b%b",
                 sel, cyc_in_frame, cur_tx, cur_busy, cur_done, e.tx, e.busy, e.done);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic set_in(logic v, int d);
    case (sel)
      1:       begin vb = v; db = 5'(d); end
      2:       begin vc = v; dc = 8'(d); end
      default: begin va = v; da = 8'(d); end
    endcase
  endtask

  task automatic wait_ready();
    int i;
    @(negedge clk);
    for (i = 0; i < 300 && cur_ready !== 1'b1; i++) @(negedge clk);
    if (cur_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL ready_timeout sel=%0d: o_ready got %b want 1", sel, cur_ready);
    end
  endtask

  task automatic start_frame(int d);
    wait_ready();
    set_in(1'b1, d);
    @(posedge clk);
    #1;
    cyc_in_frame = 0;
    push_frame(sel, d);
    set_in(1'b0, d);
  endtask

  task automatic drain_and_check(string name);
    for (int i = 0; i < 500 && expq.size() != 0; i++) @(posedge clk);
    #1;
    n_checks++;
    if (expq.size() != 0) begin
      $display("FAIL %s drain_timeout: %0d entries left want 0", name, expq.size());
      expq.delete();
    end else if (cur_ready !== 1'b1 || cur_tx !== 1'b1 || cur_busy !== 1'b0) begin
      $display("FAIL %s post_frame: ready/tx/busy got %b%b%b want 110",
               name, cur_ready, cur_tx, cur_busy);
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    va = 1'b1; vb = 1'b0; vc = 1'b0;
    da = 8'hFF; db = '0; dc = '0;
    sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      n_checks++;
      if (cur_tx !== 1'b1 || cur_busy !== 1'b0 || cur_done !== 1'b0 || cur_ready !== 1'b1) begin
        $display("FAIL reset_state sel=%0d: tx/busy/done/ready got %b%b%b%b want 1001",
                 s, cur_tx, cur_busy, cur_done, cur_ready);
      end else begin
        n_pass++;
      end
    end
    sel = 0;
    reset = 1'b0;
    va = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (ba !== 1'b0) $display("FAIL reset_priority: o_busy got %b want 0", ba);
    else n_pass++;
  endtask

  task automatic test_frame();
    sel = 0;
    start_frame(8'hA5);
    drain_and_check("frame_a5");
    start_frame(8'h3E);
    drain_and_check("frame_3e");
  endtask

  task automatic test_parity();
    sel = 0;
    start_frame(8'h07);
    drain_and_check("parity_even_07");
    sel = 2;
    start_frame(8'h07);
    drain_and_check("parity_odd_07");
    sel = 0;
  endtask

  task automatic test_back_to_back();
    exp_t mark;
    sel = 0;
    wait_ready();
    set_in(1'b1, 8'h00);
    @(posedge clk);
    #1;
    cyc_in_frame = 0;
    push_frame(0, 8'h00);
    mark.tx = 1'b1; mark.busy = 1'b0; mark.done = 1'b0;
    expq.push_back(mark);
    push_frame(0, 8'hFF);
    set_in(1'b1, 8'hFF);
    repeat (frame_len(0)) @(posedge clk);
    #1;
    n_checks++;
    if (ra !== 1'b1) $display("FAIL b2b_ready: o_ready at cycle N+1 got %b want 1", ra);
    else n_pass++;
    @(posedge clk);
    #1;
    set_in(1'b0, 8'hFF);
    drain_and_check("back_to_back");
  endtask

  task automatic test_five_bit();
    sel = 1;
    start_frame(5'h1F);
    drain_and_check("five_bit_1f");
    start_frame(5'h0A);
    drain_and_check("five_bit_0a");
    sel = 0;
  endtask

  task automatic test_reset_midframe();
    logic saw_done;
    sel = 0;
    wait_ready();
    set_in(1'b1, 8'h5A);
    @(posedge clk);
    #1;
    set_in(1'b0, 8'h5A);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (ta !== 1'b1 || ba !== 1'b0 || na !== 1'b0)
      $display("FAIL reset_mid: tx/busy/done got %b%b%b want 100", ta, ba, na);
    else n_pass++;
    saw_done = 1'b0;
    for (int i = 0; i < frame_len(0) + 4; i++) begin
      @(negedge clk);
      if (na === 1'b1 || ba === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL reset_mid_quiet: done/busy seen got 1 want 0");
    else n_pass++;
    start_frame(8'h3C);
    drain_and_check("after_reset_3c");
  endtask

  task automatic test_perturb();
    logic saw_busy;
    sel = 0;
    start_frame(8'h96);
    for (int k = 0; k < 3; k++) begin
      repeat (8) @(posedge clk);
      #1;
      set_in(1'b1, int'($urandom_range(0, 255)));
      @(posedge clk);
      #1;
      set_in(1'b0, int'($urandom_range(0, 255)));
    end
    drain_and_check("perturb_96");
    saw_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ba !== 1'b0) saw_busy = 1'b1;
    end
    n_checks++;
    if (saw_busy !== 1'b0) $display("FAIL perturb_no_second: o_busy seen got 1 want 0");
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc_in_frame = 0;
    test_reset();
    test_frame();
    test_parity();
    test_back_to_back();
    test_five_bit();
    test_reset_midframe();
    test_perturb();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
